// File: rtl/irrigation_pkg.sv
// Shared code map, target/state enums and the mode-to-target decode for the
// irrigation valve decoder.
package irrigation_pkg;

   localparam logic [1:0] CODE_OFF  = 2'b00;
   localparam logic [1:0] CODE_DRIP = 2'b01;
   localparam logic [1:0] CODE_SPR  = 2'b10;
   localparam logic [1:0] CODE_AUTO = 2'b11;

   typedef enum logic [1:0] {TGT_NONE, TGT_DRIP, TGT_SPR} target_t;

   typedef enum logic [1:0] {ST_CLOSED, ST_DRIP_ON, ST_SPR_ON, ST_DEAD} state_t;

   // AUTO waters with drip only while the soil reads dry.
   function automatic target_t decode_target(input logic [1:0] code, input logic dry);
      target_t t;
      t = TGT_NONE;
      case (code)
         CODE_DRIP: t = TGT_DRIP;
         CODE_SPR:  t = TGT_SPR;
         CODE_AUTO: t = dry ? TGT_DRIP : TGT_NONE;
         default:   t = TGT_NONE;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/irrigation_code_debouncer.sv
// Registers the incoming mode code once and accepts it only after it has held
// steady for STABLE_CYCLES consecutive samples.
module irrigation_code_debouncer #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       b1,
   input  logic       b0,
   output logic [1:0] mode,
   output logic       mode_valid
);
   import irrigation_pkg::*;

   localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [1:0]       code_q;
   logic [1:0]       candidate;
   logic [CNT_W-1:0] stab_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         code_q     <= CODE_OFF;
         candidate  <= CODE_OFF;
         stab_cnt   <= '0;
         mode       <= CODE_OFF;
         mode_valid <= 1'b0;
      end else begin
         code_q <= {b1, b0};
         if (code_q != candidate) begin
            candidate <= code_q;
            stab_cnt  <= '0;
         end else if (stab_cnt != STAB_LAST) begin
            stab_cnt <= stab_cnt + 1'b1;
         end
         if (stab_cnt == STAB_LAST) begin
            mode       <= candidate;
            mode_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/irrigation_valve_decoder.sv
// Debounced mode decode driving the sprinkler and drip valves with minimum
// on-time, a closed dead time between valve changes, and mutual exclusion.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_CLOSED  | both valves closed, waiting for a target valve
// ST_DRIP_ON | drip valve open, on_cnt tracks minimum on-time
// ST_SPR_ON  | sprinkler valve open, on_cnt tracks minimum on-time
// ST_DEAD    | both valves forced closed for DEAD_CYCLES before reopening
module irrigation_valve_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int MIN_ON_CYCLES = 16,
   parameter int DEAD_CYCLES   = 8,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       b1,
   input  logic       b0,
   input  logic       dry,
   output logic [1:0] mode,
   output logic       mode_valid,
   output logic       sprinkler_valve,
   output logic       drip_valve,
   output logic       busy
);
   import irrigation_pkg::*;

   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

   logic             dry_q;
   target_t          target;
   state_t           state;
   logic [CNT_W-1:0] on_cnt;
   logic [CNT_W-1:0] dead_cnt;
   logic             off_target;

   irrigation_code_debouncer #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_debouncer (
      .clk        (clk),
      .reset      (reset),
      .b1         (b1),
      .b0         (b0),
      .mode       (mode),
      .mode_valid (mode_valid)
   );

   assign target = decode_target(mode, dry_q);

   // Open valve no longer matches what the mode asks for.
   assign off_target = ((state == ST_DRIP_ON) && (target != TGT_DRIP)) ||
                       ((state == ST_SPR_ON)  && (target != TGT_SPR));

   assign busy = (state == ST_DEAD) || off_target;

   always_ff @(posedge clk) begin
      if (reset) begin
         dry_q           <= 1'b0;
         state           <= ST_CLOSED;
         on_cnt          <= '0;
         dead_cnt        <= '0;
         sprinkler_valve <= 1'b0;
         drip_valve      <= 1'b0;
      end else begin
         dry_q <= dry;
         case (state)
            ST_CLOSED: begin
               on_cnt <= '0;
               if (target == TGT_DRIP) begin
                  state      <= ST_DRIP_ON;
                  drip_valve <= 1'b1;
               end else if (target == TGT_SPR) begin
                  state           <= ST_SPR_ON;
                  sprinkler_valve <= 1'b1;
               end
            end
            ST_DRIP_ON, ST_SPR_ON: begin
               if (on_cnt != ON_LAST) on_cnt <= on_cnt + 1'b1;
               if (off_target && (on_cnt == ON_LAST)) begin
                  state           <= ST_DEAD;
                  dead_cnt        <= '0;
                  drip_valve      <= 1'b0;
                  sprinkler_valve <= 1'b0;
               end
            end
            ST_DEAD: begin
               if (dead_cnt == DEAD_LAST) begin
                  dead_cnt <= '0;
                  on_cnt   <= '0;
                  if (target == TGT_DRIP) begin
                     state      <= ST_DRIP_ON;
                     drip_valve <= 1'b1;
                  end else if (target == TGT_SPR) begin
                     state           <= ST_SPR_ON;
                     sprinkler_valve <= 1'b1;
                  end else begin
                     state <= ST_CLOSED;
                  end
               end else begin
                  dead_cnt <= dead_cnt + 1'b1;
               end
            end
            default: begin
               state           <= ST_CLOSED;
               drip_valve      <= 1'b0;
               sprinkler_valve <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irrigation_valve_decoder.sv
// Self-checking bench for irrigation_valve_decoder against a behavioural model
// of the debounce, valve timing and exclusion rules.
module tb_irrigation_valve_decoder;

   localparam int STABLE = 4;
   localparam int MIN_ON = 16;
   localparam int DEAD   = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       b1 = 1'b0;
   logic       b0 = 1'b0;
   logic       dry = 1'b0;
   logic [1:0] mode;
   logic       mode_valid;
   logic       sprinkler_valve;
   logic       drip_valve;
   logic       busy;

   int errors = 0;
   int checks = 0;

   irrigation_valve_decoder dut (
      .clk             (clk),
      .reset           (reset),
      .b1              (b1),
      .b0              (b0),
      .dry             (dry),
      .mode            (mode),
      .mode_valid      (mode_valid),
      .sprinkler_valve (sprinkler_valve),
      .drip_valve      (drip_valve),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // Model: m_open 0=none 1=drip 2=sprinkler; hist = synced code samples seen at recent edges.
   int m_code, m_dry, m_mode, m_valid, m_open, m_dead, m_age, m_dead_age;
   int hist[$];

   function automatic int want(input int code, input int d);
      case (code)
         1:       return 1;
         2:       return 2;
         3:       return (d != 0) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   task automatic model_edge(input logic r, input logic [1:0] c, input logic d);
      int  tgt;
      bit  same;
      if (r) begin
         m_code = 0; m_dry = 0; m_mode = 0; m_valid = 0;
         m_open = 0; m_dead = 0; m_age = 0; m_dead_age = 0;
         hist.delete();
         hist.push_back(0);
      end else begin
         tgt = want(m_mode, m_dry);
         if (m_dead != 0) begin
            if (m_dead_age == DEAD - 1) begin
               m_dead = 0; m_open = tgt; m_age = 0;
            end else m_dead_age++;
         end else if (m_open == 0) begin
            m_open = tgt; m_age = 0;
         end else if (tgt != m_open && m_age >= MIN_ON - 1) begin
            m_open = 0; m_dead = 1; m_dead_age = 0;
         end else m_age++;
         if (hist.size() == STABLE) begin
            same = 1'b1;
            foreach (hist[k]) if (hist[k] != hist[0]) same = 1'b0;
            if (same) begin m_mode = hist[0]; m_valid = 1; end
         end
         hist.push_back(m_code);
         if (hist.size() > STABLE) void'(hist.pop_front());
         m_code = int'(c);
         m_dry  = int'(d);
      end
   endtask

   function automatic logic [5:0] expv();
      logic       eb;
      logic [1:0] em;
      eb = (m_dead != 0) || (m_open != 0 && want(m_mode, m_dry) != m_open);
      em = 2'(m_mode);
      return {em, m_valid != 0, m_open == 2, m_open == 1, eb};
   endfunction

   function automatic logic [5:0] obs();
      return {mode, mode_valid, sprinkler_valve, drip_valve, busy};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge(reset, {b1, b0}, dry);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; {b1, b0} = 2'b00; dry = 1'b0;
      tick(); tick();
      reset = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; {b1, b0} = 2'($urandom); dry = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (obs() !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: got %b want 000000", i, obs());
         end
         checks++;
      end
      reset = 1'b0; {b1, b0} = 2'b00; dry = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL reset_release cycle %0d: got %b want %b", i, obs(), expv());
         end
         checks++;
      end
      if ({mode, mode_valid, sprinkler_valve, drip_valve} !== 5'b00100) begin
         errors++;
         $display("FAIL reset_idle: got %b want 00100", {mode, mode_valid, sprinkler_valve, drip_valve});
      end
      checks++;
   endtask

   task automatic test_drip_open();
      int first_mode, first_drip;
      do_reset();
      first_mode = -1; first_drip = -1;
      {b1, b0} = 2'b01;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL drip_open cycle %0d: got %b want %b", i, obs(), expv());
         end
         checks++;
         if (first_mode < 0 && mode == 2'b01) first_mode = i;
         if (first_drip < 0 && drip_valve) first_drip = i;
      end
      if (first_mode != 6) begin
         errors++;
         $display("FAIL drip_mode_latency: got %0d want 6", first_mode);
      end
      checks++;
      if (first_drip != 7) begin
         errors++;
         $display("FAIL drip_valve_latency: got %0d want 7", first_drip);
      end
      checks++;
   endtask

   task automatic test_glitch();
      int bad;
      do_reset();
      bad = 0;
      {b1, b0} = 2'b10;
      for (int i = 1; i <= 18; i++) begin
         if (i == 4) {b1, b0} = 2'b00;
         tick();
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL glitch cycle %0d: got %b want %b", i, obs(), expv());
         end
         checks++;
         if (mode == 2'b10 || busy || sprinkler_valve || drip_valve) bad++;
      end
      if (bad != 0) begin
         errors++;
         $display("FAIL glitch_rejected: got %0d bad cycles want 0", bad);
      end
      checks++;
   endtask

   task automatic test_switch();
      int open_ticks, drip_cnt, gap, both;
      bit switched, was_drip, spr_seen;
      do_reset();
      open_ticks = 0; drip_cnt = 0; gap = 0; both = 0;
      switched = 0; was_drip = 0; spr_seen = 0;
      {b1, b0} = 2'b01;
      for (int i = 1; i <= 200 && !spr_seen; i++) begin
         tick();
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL switch cycle %0d: got %b want %b", i, obs(), expv());
         end
         checks++;
         if (sprinkler_valve && drip_valve) both++;
         if (drip_valve) begin drip_cnt++; was_drip = 1; end
         if (was_drip && !drip_valve && !sprinkler_valve) gap++;
         if (sprinkler_valve) spr_seen = 1;
         if (drip_valve && !switched) begin
            open_ticks++;
            if (open_ticks == 5) begin {b1, b0} = 2'b10; switched = 1; end
         end
      end
      if ({spr_seen, drip_cnt, gap} !== {1'b1, 32'd16, 32'd8}) begin
         errors++;
         $display("FAIL switch_timing: got spr=%0d drip_cycles=%0d dead=%0d want spr=1 drip_cycles=16 dead=8",
                  spr_seen, drip_cnt, gap);
      end
      checks++;
      if (both != 0) begin
         errors++;
         $display("FAIL switch_exclusive: got %0d overlap cycles want 0", both);
      end
      checks++;
   endtask

   task automatic test_auto();
      do_reset();
      {b1, b0} = 2'b11; dry = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL auto_dry cycle %0d: got %b want %b", i, obs(), expv());
         end
         checks++;
      end
      if (drip_valve !== 1'b1) begin
         errors++;
         $display("FAIL auto_drip_open: got %b want 1", drip_valve);
      end
      checks++;
      dry = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL auto_wet cycle %0d: got %b want %b", i, obs(), expv());
         end
         checks++;
      end
      if ({sprinkler_valve, drip_valve, busy} !== 3'b000) begin
         errors++;
         $display("FAIL auto_closed: got %b want 000", {sprinkler_valve, drip_valve, busy});
      end
      checks++;
   endtask

   task automatic test_reset_in_dead();
      int first_spr;
      bit hit;
      do_reset();
      hit = 0;
      {b1, b0} = 2'b01;
      for (int i = 1; i <= 100 && !hit; i++) begin
         tick();
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL dead_entry cycle %0d: got %b want %b", i, obs(), expv());
         end
         checks++;
         if (drip_valve) {b1, b0} = 2'b10;
         if (m_dead != 0 && m_dead_age == 2) hit = 1;
      end
      if (!hit) begin
         errors++;
         $display("FAIL dead_reached: got timeout want dead cycle 3");
      end
      checks++;
      reset = 1'b1;
      tick();
      if (obs() !== 6'b0) begin
         errors++;
         $display("FAIL dead_reset: got %b want 000000", obs());
      end
      checks++;
      reset = 1'b0;
      first_spr = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL post_reset cycle %0d: got %b want %b", i, obs(), expv());
         end
         checks++;
         if (first_spr < 0 && sprinkler_valve) first_spr = i;
      end
      if (first_spr != 7) begin
         errors++;
         $display("FAIL post_reset_spr_latency: got %0d want 7", first_spr);
      end
      checks++;
   endtask

   task automatic test_random();
      int both, hold;
      both = 0;
      do_reset();
      for (int seg = 0; seg < 60; seg++) begin
         reset = ($urandom_range(0, 39) == 0);
         {b1, b0} = 2'($urandom);
         dry = 1'($urandom);
         hold = $urandom_range(1, 24);
         for (int i = 0; i < hold; i++) begin
            if ($urandom_range(0, 9) == 0) dry = ~dry;
            tick();
            reset = 1'b0;
            if (obs() !== expv()) begin
               errors++;
               $display("FAIL random seg %0d cycle %0d: got %b want %b", seg, i, obs(), expv());
            end
            checks++;
            if (sprinkler_valve && drip_valve) both++;
         end
      end
      if (both != 0) begin
         errors++;
         $display("FAIL random_exclusive: got %0d overlap cycles want 0", both);
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_drip_open();
      test_glitch();
      test_switch();
      test_auto();
      test_reset_in_dead();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
